io_port_responder: RTL



---
 rtl/io_port_if.sv | 27 ++
 rtl/io_port_responder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/io_port_if.sv
// Core/device-side bus of io_port_responder: IO strobes and read data toward the core,
// plus the TX and RX valid/ready streams toward the device.
interface io_port_if;
  logic [7:0] port_id;
  logic [7:0] io_write_data;
  logic       io_write_strobe;
  logic       io_read_strobe;
  logic [7:0] io_read_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output port_id, io_write_data, io_write_strobe, io_read_strobe,
    output tx_ready, rx_data, rx_valid,
    input  io_read_data, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  port_id, io_write_data, io_write_strobe, io_read_strobe,
    input  tx_ready, rx_data, rx_valid,
    output io_read_data, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/io_port_responder.sv
// Peripheral responder for the core's INPUT/OUTPUT instructions: output registers, synchronized
// inputs, TX/RX FIFOs and sticky status. Define IO_IRQ_EN to add the irq output and mask at 0xF2.
module io_port_responder #(
  parameter int NUM_OUT_PORTS = 4,
  parameter int NUM_IN_PORTS  = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  io_port_if.slave                   bus,
  output logic [NUM_OUT_PORTS*8-1:0] out_ports,
  input  logic [NUM_IN_PORTS*8-1:0]  in_ports
`ifdef IO_IRQ_EN
  ,
  output logic                       irq
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  localparam cnt_t FULL_CNT = cnt_t'(FIFO_DEPTH);

  localparam logic [7:0] ID_FIFO     = 8'hF0;
  localparam logic [7:0] ID_STATUS   = 8'hF1;
`ifdef IO_IRQ_EN
  localparam logic [7:0] ID_IRQ_MASK = 8'hF2;
`endif

  logic [7:0] port_id_q;
  logic [NUM_IN_PORTS*8-1:0]  in_meta, in_sync;
  logic [NUM_OUT_PORTS*8-1:0] out_q;

  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];
  ptr_t tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  cnt_t tx_cnt, rx_cnt;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_overflow, rx_underflow;

  logic wr_stb, rd_stb;
  logic tx_push_req, tx_push, tx_pop;
  logic rx_pop_req, rx_pop, rx_push;
  logic status_clr;
  logic [7:0] status;
  logic [7:0] rd_data;

  // Strobes arrive one cycle after the port ID they belong to, so decode the delayed ID.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      port_id_q <= '0;
      in_meta   <= '0;
      in_sync   <= '0;
    end else begin
      port_id_q <= bus.port_id;
      in_meta   <= in_ports;
      in_sync   <= in_meta;
    end
  end

  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);

  // A simultaneous read strobe is illegal; the write wins and the read side effect is dropped.
  assign wr_stb      = bus.io_write_strobe;
  assign rd_stb      = bus.io_read_strobe && !bus.io_write_strobe;
  assign tx_push_req = wr_stb && (port_id_q == ID_FIFO);
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_pop      = !tx_empty && bus.tx_ready;
  assign rx_pop_req  = rd_stb && (port_id_q == ID_FIFO);
  assign rx_pop      = rx_pop_req && !rx_empty;
  assign rx_push     = bus.rx_valid && !rx_full;
  assign status_clr  = rd_stb && (port_id_q == ID_STATUS);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else if (wr_stb) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (port_id_q == 8'(i)) out_q[i*8 +: 8] <= bus.io_write_data;
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the counts alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= bus.io_write_data;
    if (rx_push) rx_mem[rx_wptr] <= bus.rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      tx_cnt  <= '0;
      rx_wptr <= '0;
      rx_rptr <= '0;
      rx_cnt  <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + ptr_t'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + ptr_t'(1);
      tx_cnt <= tx_cnt + cnt_t'(tx_push) - cnt_t'(tx_pop);
      if (rx_push) rx_wptr <= rx_wptr + ptr_t'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + ptr_t'(1);
      rx_cnt <= rx_cnt + cnt_t'(rx_push) - cnt_t'(rx_pop);
    end
  end

  // Setting a sticky error outranks a status-read clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      if (tx_push_req && tx_full)    tx_overflow <= 1'b1;
      else if (status_clr)           tx_overflow <= 1'b0;
      if (rx_pop_req && rx_empty)    rx_underflow <= 1'b1;
      else if (status_clr)           rx_underflow <= 1'b0;
    end
  end

  assign status = {3'b000, rx_underflow, tx_overflow, rx_full, rx_empty, tx_full};

`ifdef IO_IRQ_EN
  logic [7:0] irq_mask;
  logic [2:0] irq_cause;

  assign irq_cause = {tx_overflow | rx_underflow, tx_empty, !rx_empty};

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_stb && (port_id_q == ID_IRQ_MASK)) irq_mask <= bus.io_write_data;
      irq <= |(irq_mask[2:0] & irq_cause);
    end
  end
`endif

  // Read data follows the live EX-stage port ID.
  // NOTE: rd_data gets its default first so no path through this block can infer a latch.
  always_comb begin
    rd_data = 8'h00;
    if (bus.port_id == ID_FIFO) begin
      rd_data = rx_empty ? 8'h00 : rx_mem[rx_rptr];
    end else if (bus.port_id == ID_STATUS) begin
      rd_data = status;
`ifdef IO_IRQ_EN
    end else if (bus.port_id == ID_IRQ_MASK) begin
      rd_data = irq_mask;
`endif
    end else begin
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
        if (bus.port_id == 8'(i)) rd_data = in_sync[i*8 +: 8];
      end
    end
  end

  assign bus.io_read_data = rd_data;
  assign bus.tx_data      = tx_mem[tx_rptr];
  assign bus.tx_valid     = !tx_empty;
  assign bus.rx_ready     = !rx_full;
  assign out_ports        = out_q;

endmodule
